ttc_trig_sequencer: RTL
=======================

Name: ttc_trig_sequencer

Overview:
- Sequences one trigger through the L0 -> L1 -> L2accept/L2reject protocol.
- Inputs are the decoded TTC trigger pulses (L0, L1, L2a, L2r) from the TTC decoder.
- Enforces L1 and L2 latency windows, drives busy, starts and aborts FEE readout, and reports protocol errors on a 6-bit trigger-error vector feeding the CDH.
- Sits between the TTC decoder and the readout controller, in the gclk_40m domain.

Parameters:
- CNT_W, 16: width of the latency counter.
- L1_MIN, 200: earliest legal L1 after L0, in clocks.
- L1_MAX, 260: latest legal L1 after L0, in clocks; must satisfy L1_MIN < L1_MAX < 2^CNT_W.
- L2_TIMEOUT, 4000: maximum clocks from L1 to L2a/L2r.

Ports:
- gclk_40m, in, 1: system clock, 40 MHz.
- reset, in, 1: asynchronous, active-high reset.
- trig_mode, in, 1: 0 = TTC mode; 1 = software/un-TTC mode.
- sw_trig, in, 1: one-cycle software trigger, used only when trig_mode=1.
- ttc_l0, in, 1: one-cycle L0 pulse.
- ttc_l1, in, 1: one-cycle L1 pulse.
- ttc_l2a, in, 1: one-cycle L2accept strobe.
- ttc_l2r, in, 1: one-cycle L2reject strobe.
- rdo_done, in, 1: readout controller finished the event.
- err_clr, in, 1: clears trigerr.
- rdo_start, out, 1: one-cycle pulse that starts event readout.
- rdo_abort, out, 1: one-cycle pulse that discards buffered L1 data.
- busy, out, 1: high when not IDLE.
- trigerr, out, 6: sticky protocol error flags.
- l2a_cnt, out, 16: accepted-event counter (see Optional Feature).

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0. All outputs are registered.
- States: IDLE, WAIT_L1, WAIT_L2, READOUT, one-hot encoded. An illegal encoding returns to IDLE.
- Counter: cleared on every state entry; increments once per cycle in WAIT_L1 and WAIT_L2; never wraps (windows are bounded by the parameters).
- IDLE, trig_mode=0: ttc_l0 -> WAIT_L1. busy rises on the following edge (1-cycle latency).
- IDLE, trig_mode=1: sw_trig -> READOUT, with rdo_start pulsed in the same edge as the state change. TTC pulses are ignored in this mode.
- WAIT_L1, ttc_l1 with cnt < L1_MIN: set trigerr[0], pulse rdo_abort, go to IDLE.
- WAIT_L1, ttc_l1 with L1_MIN <= cnt <= L1_MAX: go to WAIT_L2.
- WAIT_L1, cnt == L1_MAX and no ttc_l1: set trigerr[1], go to IDLE. No abort is issued (no L1 data exists).
- WAIT_L2, ttc_l2a alone: pulse rdo_start, go to READOUT.
- WAIT_L2, ttc_l2r alone: pulse rdo_abort, go to IDLE.
- WAIT_L2, ttc_l2a and ttc_l2r in the same cycle: treat as reject, set trigerr[4].
- WAIT_L2, cnt == L2_TIMEOUT: set trigerr[2], pulse rdo_abort, go to IDLE.
- READOUT: rdo_done -> IDLE. There is no timeout in this state.
- Spurious pulses:
  - ttc_l1 in IDLE or READOUT sets trigerr[3].
  - ttc_l2a or ttc_l2r in IDLE, WAIT_L1 or READOUT sets trigerr[4].
  - ttc_l0 while busy sets trigerr[5] and is ignored; no state change.
- trigerr: bits are sticky and OR-accumulate. err_clr zeroes them on the next edge. If err_clr coincides with a new error, the new error wins (bit remains set).
- rdo_start and rdo_abort are never high in the same cycle.
- Reset mid-sequence returns to IDLE immediately with no abort pulse; downstream logic must reset on the same reset.
- Changing trig_mode is only honoured in IDLE. A change while busy takes effect after return to IDLE.

Optional Feature:
- Macro: TRIG_SEQ_L2A_CNT_EN.
- Defined: l2a_cnt increments by 1 on each rdo_start in either mode, saturates at 16'hFFFF, and is cleared by reset only.
- Undefined: l2a_cnt is tied to 16'h0000 and no counter logic is synthesised.

Test Plan:
- Nominal accept (trig_mode=0): L0; L1 at 230 clocks; L2a 1000 clocks later -> busy high from cycle after L0; one-cycle rdo_start; rdo_done returns busy to 0; trigerr=6'h00; l2a_cnt=1 with the macro defined.
- Early L1: L1 at 150 clocks after L0 -> trigerr=6'h01, one rdo_abort pulse, IDLE. A following L0 is accepted normally.
- Missing L1: no L1 after L0 -> IDLE exactly 261 cycles after L0 entry; trigerr=6'h02; no abort pulse.
- L2 timeout and simultaneous L2: no L2 -> trigerr[2] set and abort pulse at cnt 4000. Separately, L2a and L2r in the same cycle -> abort pulse, trigerr[4], no rdo_start.
- Spurious/overlap: L0 during READOUT -> trigerr=6'h20, state unchanged. Then err_clr -> trigerr=0. err_clr together with a stray L1 in IDLE -> trigerr=6'h08.
- Software mode and reset: trig_mode=1, sw_trig -> rdo_start in the next cycle, TTC L0 ignored. Async reset asserted during WAIT_L2 -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/ttc_trig_sequencer.sv
// ttc_trig_sequencer
// Tracks one trigger through L0 -> L1 -> L2accept/L2reject in the gclk_40m
// domain. It checks the L1 and L2 latency windows, drives busy, starts or
// aborts FEE readout, and accumulates sticky protocol errors for the CDH.
//
// Build option: define TRIG_SEQ_L2A_CNT_EN to enable the saturating
// accepted-event counter on l2a_cnt. When it is undefined, l2a_cnt is
// tied to zero and no counter logic is built.
//
// Pulse semantics: the ttc_* and sw_trig inputs are one-cycle strobes.
// Each one is sampled on exactly one rising edge of gclk_40m.
// rdo_start and rdo_abort are registered one-cycle strobes that change on
// the same edge as the state transition they belong to. They are mutually
// exclusive, and there is no ready/acknowledge back-pressure on either side.
module ttc_trig_sequencer #(
  parameter int CNT_W      = 16,
  parameter int L1_MIN     = 200,
  parameter int L1_MAX     = 260,
  parameter int L2_TIMEOUT = 4000
) (
  input  logic        gclk_40m,
  input  logic        reset,
  input  logic        trig_mode,
  input  logic        sw_trig,
  input  logic        ttc_l0,
  input  logic        ttc_l1,
  input  logic        ttc_l2a,
  input  logic        ttc_l2r,
  input  logic        rdo_done,
  input  logic        err_clr,
  output logic        rdo_start,
  output logic        rdo_abort,
  output logic        busy,
  output logic [5:0]  trigerr,
  output logic [15:0] l2a_cnt
);

  localparam logic [CNT_W-1:0] L1_MIN_C = CNT_W'(L1_MIN);
  localparam logic [CNT_W-1:0] L1_MAX_C = CNT_W'(L1_MAX);
  localparam logic [CNT_W-1:0] L2_TO_C  = CNT_W'(L2_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_TOP  = {CNT_W{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_WAIT_L1 = 4'b0010,
    S_WAIT_L2 = 4'b0100,
    S_READOUT = 4'b1000
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             abort_q, abort_d;
  logic             busy_q, busy_d;
  logic [5:0]       trigerr_q, trigerr_d;
  logic [5:0]       err_set;

  // Next-state, strobe and error-flag decode for the protocol FSM
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    err_set = 6'h00;
    case (state_q)
      S_IDLE: begin
        if (!trig_mode) begin
          if (ttc_l0)             state_d = S_WAIT_L1;
          if (ttc_l1)             err_set[3] = 1'b1;
          if (ttc_l2a || ttc_l2r) err_set[4] = 1'b1;
        end else if (sw_trig) begin
          // Software mode skips the TTC handshake and ignores TTC strobes
          state_d = S_READOUT;
          start_d = 1'b1;
        end
      end
      S_WAIT_L1: begin
        if (ttc_l0)             err_set[5] = 1'b1;
        if (ttc_l2a || ttc_l2r) err_set[4] = 1'b1;
        if (ttc_l1) begin
          if (cnt_q < L1_MIN_C) begin
            err_set[0] = 1'b1;
            abort_d    = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_WAIT_L2;
          end
        end else if (cnt_q >= L1_MAX_C) begin
          // No L1 arrived, so there is no buffered data to abort
          err_set[1] = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_WAIT_L2: begin
        if (ttc_l0) err_set[5] = 1'b1;
        if (ttc_l2a && ttc_l2r) begin
          // A conflicting decision is treated as a reject
          err_set[4] = 1'b1;
          abort_d    = 1'b1;
          state_d    = S_IDLE;
        end else if (ttc_l2a) begin
          start_d = 1'b1;
          state_d = S_READOUT;
        end else if (ttc_l2r) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q >= L2_TO_C) begin
          err_set[2] = 1'b1;
          abort_d    = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_READOUT: begin
        if (ttc_l0)             err_set[5] = 1'b1;
        if (ttc_l1)             err_set[3] = 1'b1;
        if (ttc_l2a || ttc_l2r) err_set[4] = 1'b1;
        if (rdo_done)           state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latency counter restarts on every state entry and runs in the wait states
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == S_WAIT_L1 || state_q == S_WAIT_L2) &&
        cnt_q != CNT_TOP) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Sticky error accumulation; a new error outranks a simultaneous clear
  always_comb begin
    trigerr_d = (err_clr ? 6'h00 : trigerr_q) | err_set;
    busy_d    = (state_d != S_IDLE);
  end

  // State, counter and registered outputs
  always_ff @(posedge gclk_40m or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      trigerr_q <= 6'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      abort_q   <= abort_d;
      busy_q    <= busy_d;
      trigerr_q <= trigerr_d;
    end
  end

  assign rdo_start = start_q;
  assign rdo_abort = abort_q;
  assign busy      = busy_q;
  assign trigerr   = trigerr_q;

`ifdef TRIG_SEQ_L2A_CNT_EN
  logic [15:0] l2a_cnt_q;

  // Saturating count of readout starts, cleared only by reset
  always_ff @(posedge gclk_40m or posedge reset) begin
    if (reset) begin
      l2a_cnt_q <= 16'h0000;
    end else if (start_d && l2a_cnt_q != 16'hFFFF) begin
      l2a_cnt_q <= l2a_cnt_q + 16'd1;
    end
  end

  assign l2a_cnt = l2a_cnt_q;
`else
  assign l2a_cnt = 16'h0000;
`endif

endmodule
